alu_control_seq: RTL and testbench
==================================

// Module: alu_control_seq
// PURPOSE
//  Parametrised, registered ALU control with multi-cycle sequencing. Decodes {funct7, ALU_Op, funct3} into an ALU operation code,
//  adds RV32M (MUL/DIV/REM), I-type and full branch decode, and flags illegal encodings. Sits between main control and ALU/MulDiv unit;
//  issues one op per valid/ready handshake, holding off new ops while an iterative MUL/DIV runs.
// PARAMETERS
//  OP_W        5   width of ALU_Operation_o (>=5)
//  MUL_CYCLES  4   MulDiv busy cycles for MUL* ops (>=1)
//  DIV_CYCLES  33  MulDiv busy cycles for DIV*/REM* ops (>=1)
//  CNT_W       6   cycle counter width; 2**CNT_W > max(MUL_CYCLES,DIV_CYCLES)
// PORTS
//  clk              in   1      clock, all state on rising edge
//  reset            in   1      synchronous, active-high reset
//  flush_i          in   1      abort in-flight multi-cycle op
//  valid_i          in   1      decode request valid
//  funct7_i         in   7      instruction[31:25]
//  ALU_Op_i         in   3      class from main control
//  funct3_i         in   3      instruction[14:12]
//  ready_o          out  1      request accepted when valid_i & ready_o
//  op_valid_o       out  1      1-cycle pulse: ALU_Operation_o/illegal_o valid
//  ALU_Operation_o  out  OP_W   operation code, held between pulses
//  illegal_o        out  1      encoding unsupported (qualified by op_valid_o)
//  mc_start_o       out  1      1-cycle pulse starting MulDiv unit
//  mc_busy_o        out  1      multi-cycle op in flight
// BEHAVIOUR
//  Op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 6, SRL 7, SRA 8, LUI 9, SLT 10, SLTU 11, MUL..REMU 16+funct3 (16..23).
//  Decode, ALU_Op 000 (R-type): funct7 0000000 -> f3 000 ADD,001 SLL,010 SLT,011 SLTU,100 XOR,101 SRL,110 OR,111 AND;
//    funct7 0100000 -> f3 000 SUB, 101 SRA, else illegal; funct7 0000001 -> 16+f3 (multi-cycle); any other funct7 illegal.
//  ALU_Op 011 (I-type): as R-type with funct7 ignored, except f3 001 needs funct7=0000000, f3 101 funct7 0000000 SRL / 0100000 SRA, else illegal.
//  ALU_Op 001 (branch): f3 000,001 SUB; 100,101 SLT; 110,111 SLTU; 010,011 illegal.
//  ALU_Op 010 LUI; ALU_Op 100 ADD (load/store/jalr address); ALU_Op 101/110/111 illegal.
//  Illegal: single-cycle path, ALU_Operation_o=ADD(0), illegal_o=1.
//  FSM IDLE/MC_RUN. ready_o = (state==IDLE) & !reset.
//  Accept at edge T, single-cycle op: cycle T+1 op_valid_o=1, code/illegal_o registered; state stays IDLE; back-to-back accepts allowed.
//  Accept at edge T, multi-cycle op: ALU_Operation_o loaded at T; state->MC_RUN, cnt=N-1 (N=MUL_CYCLES for 16..19, DIV_CYCLES for 20..23);
//    cycle T+1 mc_start_o=1 (once only), mc_busy_o=1, ready_o=0.
//  In MC_RUN: each edge cnt>0 -> cnt-1; edge with cnt==0 -> IDLE, next cycle op_valid_o=1, mc_busy_o=0, ready_o=1.
//    op_valid_o lands in cycle T+1+N.
//  flush_i (edge-sampled): MC_RUN -> IDLE, no op_valid_o, cnt=0; in IDLE suppresses accept (no op_valid_o next cycle).
//    flush_i wins over cnt==0 completion in the same edge.
//  Priority: reset > flush_i > completion > accept. valid_i ignored while ready_o=0; inputs need only be stable in accept cycle.
//  Reset (sync, any state incl. mid MC_RUN): state IDLE, cnt 0, op_valid_o 0, ALU_Operation_o 0, illegal_o 0, mc_start_o 0, mc_busy_o 0; ready_o 0 during reset cycle.
//  ALU_Operation_o zero-extended to OP_W; only changes on accept.
// TESTING
//  1 Accept R-type f7=0100000,f3=101 then ADD back-to-back -> op_valid_o 2 consecutive cycles, codes 8 then 0, ready_o held 1.
//  2 MUL (f7=0000001,f3=000), MUL_CYCLES=4, accept edge T -> mc_start_o at T+1 only, ready_o=0 T+1..T+4, op_valid_o code 16 at T+5.
//  3 DIVU (f3=101), DIV_CYCLES=33; flush_i at T+10 -> mc_busy_o=0 at T+11, no op_valid_o; next accept at T+11 works.
//  4 Branch f3=011 and ALU_Op=111 -> op_valid_o=1, illegal_o=1, code 0; ADDI with f7=1111111 -> code 0, illegal_o=0.
//  5 reset during MC_RUN of REM (cnt=20) -> all outputs 0 next cycle, no op_valid_o; valid_i in reset cycle not accepted.
//  6 MUL_CYCLES=1: accept at T -> mc_start_o T+1, op_valid_o T+2; flush_i and cnt==0 same edge -> no op_valid_o.

Source files
------------

// File: rtl/alu_control_seq_if.sv
// Request/response bundle between main control, the ALU control sequencer and the ALU/MulDiv side.
interface alu_control_seq_if #(
  parameter int OP_W = 5
);
  logic            flush_i;
  logic            valid_i;
  logic [6:0]      funct7_i;
  logic [2:0]      ALU_Op_i;
  logic [2:0]      funct3_i;
  logic            ready_o;
  logic            op_valid_o;
  logic [OP_W-1:0] ALU_Operation_o;
  logic            illegal_o;
  logic            mc_start_o;
  logic            mc_busy_o;

  modport master (
    output flush_i, valid_i, funct7_i, ALU_Op_i, funct3_i,
    input  ready_o, op_valid_o, ALU_Operation_o, illegal_o, mc_start_o, mc_busy_o
  );

  modport slave (
    input  flush_i, valid_i, funct7_i, ALU_Op_i, funct3_i,
    output ready_o, op_valid_o, ALU_Operation_o, illegal_o, mc_start_o, mc_busy_o
  );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control: decodes {funct7, ALU_Op, funct3} into an op code, flags illegal
// encodings and sequences iterative MUL/DIV/REM ops through an IDLE/MC_RUN handshake.
module alu_control_seq #(
  parameter int OP_W       = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input logic               clk,
  input logic               reset,
  alu_control_seq_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MC_RUN = 1'b1
  } state_t;

  typedef struct packed {
    logic       illegal;
    logic       multi;
    logic [4:0] code;
  } dec_t;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_LUI  = 5'd9;
  localparam logic [4:0] OP_SLT  = 5'd10;
  localparam logic [4:0] OP_SLTU = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd16;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  // Busy length minus one: the counter reaches zero on the last busy edge.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam dec_t DEC_ILLEGAL = '{illegal: 1'b1, multi: 1'b0, code: 5'd0};

  function automatic dec_t single(input logic [4:0] code);
    dec_t d;
    d.illegal = 1'b0;
    d.multi   = 1'b0;
    d.code    = code;
    return d;
  endfunction

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] code;
    case (f3)
      3'b000:  code = OP_ADD;
      3'b001:  code = OP_SLL;
      3'b010:  code = OP_SLT;
      3'b011:  code = OP_SLTU;
      3'b100:  code = OP_XOR;
      3'b101:  code = OP_SRL;
      3'b110:  code = OP_OR;
      3'b111:  code = OP_AND;
      default: code = OP_ADD;
    endcase
    return code;
  endfunction

  function automatic dec_t decode_r(input logic [6:0] f7, input logic [2:0] f3);
    dec_t d;
    case (f7)
      F7_BASE: d = single(base_op(f3));
      F7_ALT: begin
        if (f3 == 3'b000) begin
          d = single(OP_SUB);
        end else if (f3 == 3'b101) begin
          d = single(OP_SRA);
        end else begin
          d = DEC_ILLEGAL;
        end
      end
      F7_MULD: begin
        d.illegal = 1'b0;
        d.multi   = 1'b1;
        d.code    = OP_MUL + {2'b00, f3};
      end
      default: d = DEC_ILLEGAL;
    endcase
    return d;
  endfunction

  // Immediate forms ignore funct7 except where it selects the shift flavour.
  function automatic dec_t decode_i(input logic [6:0] f7, input logic [2:0] f3);
    dec_t d;
    case (f3)
      3'b001: begin
        if (f7 == F7_BASE) begin
          d = single(OP_SLL);
        end else begin
          d = DEC_ILLEGAL;
        end
      end
      3'b101: begin
        if (f7 == F7_BASE) begin
          d = single(OP_SRL);
        end else if (f7 == F7_ALT) begin
          d = single(OP_SRA);
        end else begin
          d = DEC_ILLEGAL;
        end
      end
      default: d = single(base_op(f3));
    endcase
    return d;
  endfunction

  function automatic dec_t decode_b(input logic [2:0] f3);
    dec_t d;
    case (f3)
      3'b000, 3'b001: d = single(OP_SUB);
      3'b100, 3'b101: d = single(OP_SLT);
      3'b110, 3'b111: d = single(OP_SLTU);
      default:        d = DEC_ILLEGAL;
    endcase
    return d;
  endfunction

  function automatic dec_t decode(input logic [6:0] f7, input logic [2:0] op, input logic [2:0] f3);
    dec_t d;
    case (op)
      3'b000:  d = decode_r(f7, f3);
      3'b001:  d = decode_b(f3);
      3'b010:  d = single(OP_LUI);
      3'b011:  d = decode_i(f7, f3);
      3'b100:  d = single(OP_ADD);
      default: d = DEC_ILLEGAL;
    endcase
    return d;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  dec_t             dec_s;
  logic [CNT_W-1:0] load_s;
  logic             accept_s;

  // Decode the presented request and pick the busy length (codes 20..23 are DIV/REM).
  always_comb begin
    dec_s  = decode(bus.funct7_i, bus.ALU_Op_i, bus.funct3_i);
    load_s = MUL_LOAD;
    if (dec_s.code[2]) begin
      load_s = DIV_LOAD;
    end else begin
      load_s = MUL_LOAD;
    end
  end

  assign bus.ready_o = (state_r == IDLE) && !reset;
  assign accept_s    = bus.valid_i && (state_r == IDLE);

  // Sequencer: reset > flush > completion > accept; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r             <= IDLE;
      cnt_r               <= CNT_ZERO;
      bus.op_valid_o      <= 1'b0;
      bus.ALU_Operation_o <= '0;
      bus.illegal_o       <= 1'b0;
      bus.mc_start_o      <= 1'b0;
      bus.mc_busy_o       <= 1'b0;
    end else begin
      bus.op_valid_o <= 1'b0;
      bus.mc_start_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.flush_i) begin
            state_r <= IDLE;
          end else if (accept_s) begin
            bus.ALU_Operation_o <= OP_W'(dec_s.code);
            bus.illegal_o       <= dec_s.illegal;
            if (dec_s.multi) begin
              state_r        <= MC_RUN;
              cnt_r          <= load_s;
              bus.mc_start_o <= 1'b1;
              bus.mc_busy_o  <= 1'b1;
            end else begin
              bus.op_valid_o <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MC_RUN: begin
          if (bus.flush_i) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            bus.mc_busy_o <= 1'b0;
          end else if (cnt_r == CNT_ZERO) begin
            state_r        <= IDLE;
            bus.mc_busy_o  <= 1'b0;
            bus.op_valid_o <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r       <= IDLE;
          cnt_r         <= CNT_ZERO;
          bus.mc_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: two instances (long and single-cycle MUL) checked every cycle
// against an edge-indexed behavioural model, plus directed scenarios with literal expectations.
module tb_alu_control_seq;
  localparam int OP_W  = 5;
  localparam int MUL_A = 4;
  localparam int DIV_A = 33;
  localparam int MUL_B = 1;
  localparam int DIV_B = 3;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  alu_control_seq_if #(.OP_W(OP_W)) if_a ();
  alu_control_seq_if #(.OP_W(OP_W)) if_b ();

  alu_control_seq #(.OP_W(OP_W), .MUL_CYCLES(MUL_A), .DIV_CYCLES(DIV_A), .CNT_W(6)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  alu_control_seq #(.OP_W(OP_W), .MUL_CYCLES(MUL_B), .DIV_CYCLES(DIV_B), .CNT_W(6)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  always #5 clk = ~clk;

  // Reference tables indexed by funct3; -1 marks an illegal branch condition.
  int r_tab [8] = '{0, 6, 10, 11, 4, 7, 3, 2};
  int b_tab [8] = '{1, 1, -1, -1, 10, 10, 11, 11};
  int n_mul [2] = '{MUL_A, MUL_B};
  int n_div [2] = '{DIV_A, DIV_B};

  // Model: busy flag plus the absolute edge number at which the running op completes.
  bit m_busy  [2];
  int m_done  [2];
  int m_code  [2];
  bit m_ill   [2];
  bit e_valid [2];
  bit e_start [2];
  int edge_n = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic ref_dec(input logic [6:0] f7, input logic [2:0] op, input logic [2:0] f3,
                         output int code, output bit ill, output bit mc);
    int f3i;
    f3i  = int'(f3);
    code = 0;
    ill  = 1'b0;
    mc   = 1'b0;
    if (op == 3'd0) begin
      if (f7 == 7'd0) code = r_tab[f3i];
      else if (f7 == 7'h20 && f3i == 0) code = 1;
      else if (f7 == 7'h20 && f3i == 5) code = 8;
      else if (f7 == 7'h01) begin code = 16 + f3i; mc = 1'b1; end
      else ill = 1'b1;
    end else if (op == 3'd3) begin
      if (f3i == 1 && f7 != 7'd0) ill = 1'b1;
      else if (f3i == 5 && f7 == 7'h20) code = 8;
      else if (f3i == 5 && f7 != 7'd0) ill = 1'b1;
      else code = r_tab[f3i];
    end else if (op == 3'd1) begin
      if (b_tab[f3i] < 0) ill = 1'b1;
      else code = b_tab[f3i];
    end else if (op == 3'd2) code = 9;
    else if (op == 3'd4) code = 0;
    else ill = 1'b1;
    if (ill) code = 0;
  endtask

  task automatic model_edge(input bit r, input bit f, input bit v,
                            input logic [6:0] f7, input logic [2:0] op, input logic [2:0] f3);
    int c;
    bit il;
    bit mc;
    ref_dec(f7, op, f3, c, il, mc);
    for (int i = 0; i < 2; i++) begin
      e_valid[i] = 1'b0;
      e_start[i] = 1'b0;
      if (r) begin
        m_busy[i] = 1'b0;
        m_code[i] = 0;
        m_ill[i]  = 1'b0;
      end else if (m_busy[i]) begin
        if (f) m_busy[i] = 1'b0;
        else if (edge_n == m_done[i]) begin
          m_busy[i]  = 1'b0;
          e_valid[i] = 1'b1;
        end
      end else if (!f && v) begin
        m_code[i] = c;
        m_ill[i]  = il;
        if (mc) begin
          m_busy[i]  = 1'b1;
          m_done[i]  = edge_n + ((c >= 20) ? n_div[i] : n_mul[i]);
          e_start[i] = 1'b1;
        end else begin
          e_valid[i] = 1'b1;
        end
      end
    end
    edge_n++;
  endtask

  task automatic cmp_inst(input int i, input string tag, input logic rdy, input logic ov,
                          input logic [OP_W-1:0] code, input logic ill, input logic st, input logic bsy);
    chk({tag, "_ready"},    int'(rdy), int'(!m_busy[i] && !reset));
    chk({tag, "_op_valid"}, int'(ov),  int'(e_valid[i]));
    chk({tag, "_mc_start"}, int'(st),  int'(e_start[i]));
    chk({tag, "_mc_busy"},  int'(bsy), int'(m_busy[i]));
    chk({tag, "_code"},     int'(code), m_code[i]);
    if (e_valid[i]) chk({tag, "_illegal"}, int'(ill), int'(m_ill[i]));
  endtask

  // One clock: drive inputs, advance the model, then check both instances at the falling edge.
  task automatic step(input bit r, input bit f, input bit v,
                      input logic [6:0] f7, input logic [2:0] op, input logic [2:0] f3);
    reset         = r;
    if_a.flush_i  = f; if_a.valid_i  = v; if_a.funct7_i = f7; if_a.ALU_Op_i = op; if_a.funct3_i = f3;
    if_b.flush_i  = f; if_b.valid_i  = v; if_b.funct7_i = f7; if_b.ALU_Op_i = op; if_b.funct3_i = f3;
    model_edge(r, f, v, f7, op, f3);
    @(posedge clk);
    @(negedge clk);
    cmp_inst(0, "a", if_a.ready_o, if_a.op_valid_o, if_a.ALU_Operation_o, if_a.illegal_o,
             if_a.mc_start_o, if_a.mc_busy_o);
    cmp_inst(1, "b", if_b.ready_o, if_b.op_valid_o, if_b.ALU_Operation_o, if_b.illegal_o,
             if_b.mc_start_o, if_b.mc_busy_o);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 3'd0);
  endtask

  initial begin
    int  c;
    bit  il;
    bit  mc;
    logic [6:0] f7;

    // Pin the reference decoder with hand-derived codes.
    ref_dec(7'h20, 3'd0, 3'd5, c, il, mc); chk("ref_sra", c, 8);
    ref_dec(7'h01, 3'd0, 3'd5, c, il, mc); chk("ref_divu", c, 21); chk("ref_divu_mc", int'(mc), 1);
    ref_dec(7'h00, 3'd1, 3'd3, c, il, mc); chk("ref_br011_ill", int'(il), 1);
    ref_dec(7'h7f, 3'd3, 3'd0, c, il, mc); chk("ref_addi", c, 0); chk("ref_addi_ill", int'(il), 0);
    ref_dec(7'h00, 3'd1, 3'd7, c, il, mc); chk("ref_bgeu", c, 11);

    step(1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 3'd0);
    chk("rst_ready", int'(if_a.ready_o), 0);
    chk("rst_code", int'(if_a.ALU_Operation_o), 0);
    chk("rst_illegal", int'(if_a.illegal_o), 0);
    step(1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 3'd0);

    // Back-to-back single-cycle ops: SRA then ADD.
    step(1'b0, 1'b0, 1'b1, 7'h20, 3'd0, 3'd5);
    chk("t1_v0", int'(if_a.op_valid_o), 1); chk("t1_c0", int'(if_a.ALU_Operation_o), 8);
    step(1'b0, 1'b0, 1'b1, 7'h00, 3'd0, 3'd0);
    chk("t1_v1", int'(if_a.op_valid_o), 1); chk("t1_c1", int'(if_a.ALU_Operation_o), 0);
    chk("t1_rdy", int'(if_a.ready_o), 1);
    idle(1);

    // MUL on instance a: four busy cycles, result pulse in the fifth.
    step(1'b0, 1'b0, 1'b1, 7'h01, 3'd0, 3'd0);
    chk("t2_start", int'(if_a.mc_start_o), 1); chk("t2_rdy", int'(if_a.ready_o), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 7'h00, 3'd4, 3'd0);
      chk("t2_busy_rdy", int'(if_a.ready_o), 0); chk("t2_nostart", int'(if_a.mc_start_o), 0);
    end
    step(1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 3'd0);
    chk("t2_done", int'(if_a.op_valid_o), 1); chk("t2_code", int'(if_a.ALU_Operation_o), 16);
    idle(1);

    // DIVU flushed on the tenth busy edge, then a fresh accept.
    step(1'b0, 1'b0, 1'b1, 7'h01, 3'd0, 3'd5);
    idle(9);
    step(1'b0, 1'b1, 1'b0, 7'h00, 3'd0, 3'd0);
    chk("t3_busy", int'(if_a.mc_busy_o), 0); chk("t3_nov", int'(if_a.op_valid_o), 0);
    step(1'b0, 1'b0, 1'b1, 7'h00, 3'd0, 3'd6);
    chk("t3_next", int'(if_a.op_valid_o), 1); chk("t3_next_c", int'(if_a.ALU_Operation_o), 3);

    // Illegal encodings and ADDI with junk funct7.
    step(1'b0, 1'b0, 1'b1, 7'h00, 3'd1, 3'd3);
    chk("t4_br_ill", int'(if_a.illegal_o), 1); chk("t4_br_c", int'(if_a.ALU_Operation_o), 0);
    step(1'b0, 1'b0, 1'b1, 7'h00, 3'd7, 3'd0);
    chk("t4_op7_ill", int'(if_a.illegal_o), 1);
    step(1'b0, 1'b0, 1'b1, 7'h7f, 3'd3, 3'd0);
    chk("t4_addi_ill", int'(if_a.illegal_o), 0); chk("t4_addi_v", int'(if_a.op_valid_o), 1);

    // REM interrupted by reset while its counter is at 20.
    step(1'b0, 1'b0, 1'b1, 7'h01, 3'd0, 3'd6);
    idle(12);
    step(1'b1, 1'b0, 1'b1, 7'h00, 3'd0, 3'd0);
    chk("t5_busy", int'(if_a.mc_busy_o), 0); chk("t5_rdy", int'(if_a.ready_o), 0);
    chk("t5_code", int'(if_a.ALU_Operation_o), 0); chk("t5_v", int'(if_a.op_valid_o), 0);
    idle(1);
    chk("t5_noacc", int'(if_a.op_valid_o), 0);

    // Single-cycle MUL on instance b, then flush on its completion edge.
    step(1'b0, 1'b0, 1'b1, 7'h01, 3'd0, 3'd1);
    chk("t6_start", int'(if_b.mc_start_o), 1);
    idle(1);
    chk("t6_done", int'(if_b.op_valid_o), 1); chk("t6_code", int'(if_b.ALU_Operation_o), 17);
    step(1'b0, 1'b0, 1'b1, 7'h01, 3'd0, 3'd0);
    step(1'b0, 1'b1, 1'b0, 7'h00, 3'd0, 3'd0);
    chk("t6_flush_v", int'(if_b.op_valid_o), 0); chk("t6_flush_b", int'(if_b.mc_busy_o), 0);
    idle(2);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           f7, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
